// File: rtl/factory_test_pkg.sv
// Shared definitions for the factory-test pattern generator and checker:
// FSM states, view-select codes, ui_in bit positions and the counter step.
package factory_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } chk_state_e;

    localparam logic [1:0] VIEW_STATUS = 2'b00;
    localparam logic [1:0] VIEW_ERR    = 2'b01;
    localparam logic [1:0] VIEW_LAST   = 2'b10;
    localparam logic [1:0] VIEW_EXP    = 2'b11;

    localparam int UI_CHECK_EN = 0;
    localparam int UI_DIR      = 1;
    localparam int UI_SEL_LO   = 2;
    localparam int UI_SEL_HI   = 3;
    localparam int UI_CLR      = 4;

    // Next pattern value: dir=0 counts up, dir=1 counts down, wrapping mod 256.
    function automatic logic [7:0] step_value(input logic [7:0] value, input logic dir);
        return dir ? (value - 8'd1) : (value + 8'd1);
    endfunction

endpackage

// File: rtl/factory_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module factory_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = &cnt_q;
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_um_factory_checker.sv
// Checker for the factory-test up/down counter pattern on uio_in: acquires lock,
// counts mismatches and exposes status on uo_out. Option macro: FACTORY_CHECKER_RESYNC_EN.
module tt_um_factory_checker
    import factory_test_pkg::*;
#(
    parameter int LOCK_LEN = 4,
    parameter int LOSS_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int MISS_W = $clog2(LOSS_LEN + 1);
    // Thresholds are compared against the count before this edge's increment.
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_LEN - 1);

    chk_state_e state_q, state_d;
    logic [7:0] exp_q, exp_d;
    logic       locked_q, locked_d;
    logic       dir_q;
    logic [7:0] last_q;

    logic       check_en;
    logic       dir;
    logic [1:0] sel;
    logic       clr;

    logic              run_inc, run_clr, run_sat;
    logic              miss_inc, miss_clr, miss_sat;
    logic              err_inc, err_sat;
    logic [RUN_W-1:0]  run_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [ERR_W-1:0]  err_cnt;

    assign check_en = ui_in[UI_CHECK_EN];
    assign dir      = ui_in[UI_DIR];
    assign sel      = ui_in[UI_SEL_HI:UI_SEL_LO];
    assign clr      = ui_in[UI_CLR];

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        locked_d = locked_q;
        run_inc  = 1'b0;
        run_clr  = 1'b0;
        miss_inc = 1'b0;
        miss_clr = 1'b0;
        err_inc  = 1'b0;
        if (!check_en) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    exp_d    = step_value(uio_in, dir);
                    run_clr  = 1'b1;
                    miss_clr = 1'b1;
                    state_d  = ST_TRACK;
                end
                ST_TRACK: begin
                    if (dir != dir_q) begin
                        // Direction reversal: re-seed rather than count a burst of errors.
                        state_d  = ST_ACQUIRE;
                        locked_d = 1'b0;
                    end else if (uio_in == exp_q) begin
                        exp_d    = step_value(exp_q, dir);
                        run_inc  = 1'b1;
                        miss_clr = 1'b1;
                        if (run_cnt >= RUN_LOCK) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_inc  = 1'b1;
                        run_clr  = 1'b1;
                        miss_inc = 1'b1;
                        if (miss_cnt >= MISS_LOSS) begin
                            locked_d = 1'b0;
                            state_d  = ST_ACQUIRE;
                        end else begin
`ifdef FACTORY_CHECKER_RESYNC_EN
                            exp_d = step_value(uio_in, dir);
`else
                            exp_d = step_value(exp_q, dir);
`endif
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            exp_q    <= 8'h00;
            locked_q <= 1'b0;
            dir_q    <= 1'b0;
            last_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            locked_q <= locked_d;
            dir_q    <= dir;
            if (check_en) begin
                last_q <= uio_in;
            end
        end
    end

    factory_sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .inc_i   (err_inc),
        .clr_i   (clr),
        .cnt_o   (err_cnt),
        .sat_o   (err_sat)
    );

    factory_sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .inc_i   (run_inc),
        .clr_i   (run_clr),
        .cnt_o   (run_cnt),
        .sat_o   (run_sat)
    );

    factory_sat_counter #(.W(MISS_W)) u_miss_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .inc_i   (miss_inc),
        .clr_i   (miss_clr),
        .cnt_o   (miss_cnt),
        .sat_o   (miss_sat)
    );

    always_comb begin
        uo_out = 8'h00;
        case (sel)
            VIEW_STATUS: uo_out = {locked_q, |err_cnt, err_sat, 3'b000, state_q};
            VIEW_ERR:    uo_out = 8'(err_cnt);
            VIEW_LAST:   uo_out = last_q;
            VIEW_EXP:    uo_out = exp_q;
            default:     uo_out = 8'h00;
        endcase
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:5], run_sat, miss_sat};

endmodule

// File: tb/tb_tt_um_factory_checker.sv
// Scoreboard bench for tt_um_factory_checker: a behavioural model pushes the expected
// {status, err, last, exp} views per edge; each test pops and compares all four views.
module tb_tt_um_factory_checker;

    localparam int LOCK_LEN = 4;
    localparam int LOSS_LEN = 3;
`ifdef FACTORY_CHECKER_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_TRK  = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vecs = 0;
    int miscmp = 0;

    logic [31:0] sb[$];

    logic [1:0] m_state;
    logic [7:0] m_exp;
    int         m_run;
    int         m_miss;
    logic       m_lock;
    int         m_err;
    logic [7:0] m_last;
    logic       m_dir;

    logic [7:0]  v;
    logic [31:0] got;
    logic [31:0] e;

    tt_um_factory_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, vectors=%0d", vecs);
        $fatal(1, "watchdog");
    end

    task automatic model_step(input logic [7:0] ui, input logic [7:0] uio, input logic rn);
        logic en, dir, clr, bad;
        logic [7:0] stp;
        if (!rn) begin
            m_state = S_IDLE; m_exp = 8'h00; m_run = 0; m_miss = 0;
            m_lock = 1'b0; m_err = 0; m_last = 8'h00; m_dir = 1'b0;
            return;
        end
        en  = ui[0];
        dir = ui[1];
        clr = ui[4];
        stp = dir ? 8'hFF : 8'h01;
        bad = 1'b0;
        if (en) m_last = uio;
        if (!en) begin
            m_state = S_IDLE;
            m_lock  = 1'b0;
        end else if (m_state == S_IDLE) begin
            m_state = S_ACQ;
        end else if (m_state == S_ACQ) begin
            m_exp = uio + stp; m_run = 0; m_miss = 0; m_state = S_TRK;
        end else if (dir != m_dir) begin
            m_state = S_ACQ; m_lock = 1'b0;
        end else if (uio == m_exp) begin
            m_exp = m_exp + stp; m_run++; m_miss = 0;
            if (m_run >= LOCK_LEN) m_lock = 1'b1;
        end else begin
            bad = 1'b1; m_run = 0; m_miss++;
            if (m_miss >= LOSS_LEN) begin
                m_lock = 1'b0; m_state = S_ACQ;
            end else begin
                m_exp = (RESYNC ? uio : m_exp) + stp;
            end
        end
        if (clr) m_err = 0;
        else if (bad && m_err < 255) m_err++;
        m_dir = dir;
    endtask

    function automatic logic [31:0] model_view();
        logic [7:0] st;
        st = {m_lock, (m_err != 0), (m_err == 255), 3'b000, m_state};
        return {st, 8'(m_err), m_last, m_exp};
    endfunction

    task automatic cyc(input logic [7:0] ui, input logic [7:0] uio);
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        model_step(ui, uio, rst_n);
        sb.push_back(model_view());
        #1;
    endtask

    task automatic views(output logic [31:0] g);
        logic [7:0] save;
        save = ui_in;
        g = 32'h0;
        for (int s = 0; s < 4; s++) begin
            ui_in[3:2] = 2'(s);
            #1;
            g[31 - 8*s -: 8] = uo_out;
        end
        ui_in = save;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(8'h00, 8'h00);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL reset_sb cyc%0d got=%h want=%h", i, got, e); end
        end
        vecs++;
        if (got !== 32'h0) begin miscmp++; $display("FAIL reset_views got=%h want=00000000", got); end
        vecs++;
        if ({uio_out, uio_oe} !== 16'h0) begin miscmp++; $display("FAIL reset_uio got=%h want=0000", {uio_out, uio_oe}); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 6; i++) begin
            cyc(8'h01, 8'h10 + 8'(i));
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL lock_sb edge%0d got=%h want=%h", i, got, e); end
            if (i == 4) begin
                vecs++;
                if (got[31] !== 1'b0) begin miscmp++; $display("FAIL lock_early got=%b want=0", got[31]); end
            end
        end
        vecs++;
        if (got[31:16] !== 16'h8200) begin miscmp++; $display("FAIL lock_status got=%h want=8200", got[31:16]); end
        v = 8'h16;
    endtask

    task automatic test_glitch();
        logic [7:0] val;
        for (int i = 0; i < 19; i++) begin
            val = (v == 8'h20) ? 8'h55 : v;
            cyc(8'h01, val);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL glitch_sb in=%h got=%h want=%h", val, got, e); end
            v = v + 8'd1;
        end
        vecs++;
        if (got[23:16] !== (RESYNC ? 8'd2 : 8'd1)) begin
            miscmp++; $display("FAIL glitch_err got=%h want=%h", got[23:16], (RESYNC ? 8'd2 : 8'd1));
        end
        vecs++;
        if (got[31] !== 1'b1) begin miscmp++; $display("FAIL glitch_lock got=%b want=1", got[31]); end
    endtask

    task automatic test_loss();
        cyc(8'h11, v);
        views(got); e = sb.pop_front(); vecs++;
        if (got !== e) begin miscmp++; $display("FAIL loss_clr_sb got=%h want=%h", got, e); end
        vecs++;
        if (got[23:16] !== 8'h00) begin miscmp++; $display("FAIL loss_clr got=%h want=00", got[23:16]); end
        v = v + 8'd1;
        for (int i = 0; i < 3; i++) begin
            cyc(8'h01, 8'hAA);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL loss_sb bad%0d got=%h want=%h", i, got, e); end
            v = v + 8'd1;
        end
        vecs++;
        if (got[31:16] !== 16'h4103) begin miscmp++; $display("FAIL loss_status got=%h want=4103", got[31:16]); end
        for (int i = 0; i < 5; i++) begin
            cyc(8'h01, v);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL relock_sb edge%0d got=%h want=%h", i, got, e); end
            if (i == 3) begin
                vecs++;
                if (got[31] !== 1'b0) begin miscmp++; $display("FAIL relock_early got=%b want=0", got[31]); end
            end
            v = v + 8'd1;
        end
        vecs++;
        if (got[31:24] !== 8'hC2) begin miscmp++; $display("FAIL relock_status got=%h want=c2", got[31:24]); end
    endtask

    task automatic test_down_wrap();
        rst_n = 1'b0;
        cyc(8'h03, 8'h00);
        void'(sb.pop_front());
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(8'h03, 8'h02 - 8'(i));
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL down_sb edge%0d got=%h want=%h", i, got, e); end
        end
        vecs++;
        if (got[31:16] !== 16'h8200) begin miscmp++; $display("FAIL down_status got=%h want=8200", got[31:16]); end
        vecs++;
        if (got[7:0] !== 8'hF6) begin miscmp++; $display("FAIL down_exp got=%h want=f6", got[7:0]); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 360; i++) begin
            cyc(8'h03, 8'h00);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL sat_sb edge%0d got=%h want=%h", i, got, e); end
        end
        vecs++;
        if (got[23:16] !== 8'hFF) begin miscmp++; $display("FAIL sat_err got=%h want=ff", got[23:16]); end
        vecs++;
        if (got[29] !== 1'b1) begin miscmp++; $display("FAIL sat_flag got=%b want=1", got[29]); end
        cyc(8'h13, 8'h00);
        views(got); e = sb.pop_front(); vecs++;
        if (got !== e) begin miscmp++; $display("FAIL sat_clr_sb got=%h want=%h", got, e); end
        vecs++;
        if (got[23:16] !== 8'h00) begin miscmp++; $display("FAIL sat_clr got=%h want=00", got[23:16]); end
    endtask

    task automatic test_midtrack();
        logic [7:0] val;
        logic [7:0] held;
        rst_n = 1'b0;
        cyc(8'h01, 8'h00);
        void'(sb.pop_front());
        rst_n = 1'b1;
        v = 8'h40;
        for (int i = 0; i < 40 && m_err < 7; i++) begin
            val = (i >= 8 && m_miss == 0) ? 8'hAA : v;
            cyc(8'h01, val);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL mid_sb edge%0d got=%h want=%h", i, got, e); end
            v = v + 8'd1;
        end
        vecs++;
        if ({got[23:16], got[25:24]} !== {8'd7, S_TRK}) begin
            miscmp++; $display("FAIL mid_err7 got=%h/%0d want=07/2", got[23:16], got[25:24]);
        end
        rst_n = 1'b0;
        cyc(8'h01, v);
        rst_n = 1'b1;
        views(got); e = sb.pop_front(); vecs++;
        if (got !== e) begin miscmp++; $display("FAIL mid_rst_sb got=%h want=%h", got, e); end
        vecs++;
        if (got !== 32'h0) begin miscmp++; $display("FAIL mid_rst_views got=%h want=00000000", got); end
        for (int i = 0; i < 9; i++) begin
            val = (i == 6) ? 8'hAA : v;
            cyc(8'h01, val);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL mid_relock_sb edge%0d got=%h want=%h", i, got, e); end
            v = v + 8'd1;
        end
        held = v - 8'd1;
        cyc(8'h00, 8'h77);
        views(got); e = sb.pop_front(); vecs++;
        if (got !== e) begin miscmp++; $display("FAIL mid_dis_sb got=%h want=%h", got, e); end
        vecs++;
        if ({got[25:24], got[23:16], got[15:8]} !== {S_IDLE, (RESYNC ? 8'd2 : 8'd1), held}) begin
            miscmp++; $display("FAIL mid_dis got=%h want=%h", {got[25:24], got[23:16], got[15:8]},
                               {S_IDLE, (RESYNC ? 8'd2 : 8'd1), held});
        end
    endtask

    task automatic test_dir_change();
        for (int i = 0; i < 6; i++) begin
            cyc(8'h01, v);
            views(got); e = sb.pop_front(); vecs++;
            if (got !== e) begin miscmp++; $display("FAIL dir_lock_sb edge%0d got=%h want=%h", i, got, e); end
            v = v + 8'd1;
        end
        cyc(8'h03, v);
        views(got); e = sb.pop_front(); vecs++;
        if (got !== e) begin miscmp++; $display("FAIL dir_sb got=%h want=%h", got, e); end
        vecs++;
        if ({got[31], got[25:24], got[23:16]} !== {1'b0, S_ACQ, (RESYNC ? 8'd2 : 8'd1)}) begin
            miscmp++; $display("FAIL dir_flip got=%h want=%h", {got[31], got[25:24], got[23:16]},
                               {1'b0, S_ACQ, (RESYNC ? 8'd2 : 8'd1)});
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_loss();
        test_down_wrap();
        test_saturate();
        test_midtrack();
        test_dir_change();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
